nios_system_nios2_mul_sequencer: RTL and testbench



---
 rtl/nios_mul_seq_pkg.sv | 35 +++
 rtl/nios_system_nios2_mul16_reg.sv | 21 ++
 rtl/nios_system_nios2_mul_sequencer.sv | 156 +++++++++++++++
 tb/tb_nios_system_nios2_mul_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_mul_seq_pkg.sv
// Shared types and constants for the Nios II sequenced 32x32 multiplier.
package nios_mul_seq_pkg;

   localparam int unsigned HALF_W = 16;
   localparam int unsigned ACC_W  = 64;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXUU = 2'b01;
   localparam logic [1:0] OP_MULXSS = 2'b10;
   localparam logic [1:0] OP_MULXSU = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StAcc,
      StCorr,
      StDone
   } state_t;

   // Place a partial product at its weight: LL at 0, HL/LH at 16, HH at 32.
   function automatic logic [ACC_W-1:0] align_pp(input logic [2*HALF_W-1:0] pp,
                                                 input logic [1:0]          sel);
      logic [ACC_W-1:0] wide;
      logic [ACC_W-1:0] res;
      wide = {{(ACC_W-2*HALF_W){1'b0}}, pp};
      case (sel)
         2'd0:    res = wide;
         2'd1:    res = wide << HALF_W;
         2'd2:    res = wide << HALF_W;
         default: res = wide << (2*HALF_W);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/nios_system_nios2_mul16_reg.sv
// 16x16 unsigned multiplier with an enabled, asynchronously cleared output register.
module nios_system_nios2_mul16_reg
   import nios_mul_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic [HALF_W-1:0]     a,
   input  logic [HALF_W-1:0]     b,
   output logic [2*HALF_W-1:0]   p
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p <= '0;
      end else if (en) begin
         p <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
      end
   end

endmodule

// File: rtl/nios_system_nios2_mul_sequencer.sv
// Sequenced 32x32 multiply: four 16x16 partial products, signed fix-up, lo/hi select.
// Optional NIOS_MUL_SEQ_EARLY_OUT_EN: MUL skips HH and the correction step (latency 4).
module nios_system_nios2_mul_sequencer
   import nios_mul_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              busy
);

   state_t               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [DATA_W-1:0]    src1_q, src2_q;
   logic [1:0]           op_q;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic                 pv_q;
   logic [1:0]           psel_q;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_W-1:0]    out_result_q, out_result_d;
   logic                 mul_en;
   logic [HALF_W-1:0]    mul_a, mul_b;
   logic [2*HALF_W-1:0]  mul_p;
   logic                 early_mul;
   logic [1:0]           last_idx;
   logic [DATA_W-1:0]    corr_hi;
   logic                 accept;

`ifdef NIOS_MUL_SEQ_EARLY_OUT_EN
   assign early_mul = (op_q == OP_MUL);
`else
   assign early_mul = 1'b0;
`endif

   assign last_idx = early_mul ? 2'd2 : 2'd3;
   assign accept   = (state_q == StIdle) && in_valid;

   // idx bit 0 picks A.hi, bit 1 picks B.hi: LL, HL, LH, HH.
   assign mul_a = idx_q[0] ? src1_q[DATA_W-1:HALF_W] : src1_q[HALF_W-1:0];
   assign mul_b = idx_q[1] ? src2_q[DATA_W-1:HALF_W] : src2_q[HALF_W-1:0];

   nios_system_nios2_mul16_reg u_mul16 (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (mul_en),
      .a       (mul_a),
      .b       (mul_b),
      .p       (mul_p)
   );

   // Signed operands: subtract the other operand for each negative signed input.
   always_comb begin
      corr_hi = acc_q[ACC_W-1:DATA_W];
      if (((op_q == OP_MULXSS) || (op_q == OP_MULXSU)) && src1_q[DATA_W-1]) begin
         corr_hi = corr_hi - src2_q;
      end
      if ((op_q == OP_MULXSS) && src2_q[DATA_W-1]) begin
         corr_hi = corr_hi - src1_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      mul_en       = 1'b0;

      if (pv_q) begin
         acc_d = acc_q + align_pp(mul_p, psel_q);
      end

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StIssue;
               idx_d   = 2'd0;
               acc_d   = '0;
            end
         end
         StIssue: begin
            mul_en = 1'b1;
            if (idx_q == last_idx) begin
               state_d = StAcc;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         StAcc: begin
            if (early_mul) begin
               out_result_d = acc_d[DATA_W-1:0];
               out_valid_d  = 1'b1;
               state_d      = StDone;
            end else begin
               state_d = StCorr;
            end
         end
         StCorr: begin
            out_result_d = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : corr_hi;
            out_valid_d  = 1'b1;
            state_d      = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         idx_q        <= 2'd0;
         src1_q       <= '0;
         src2_q       <= '0;
         op_q         <= OP_MUL;
         acc_q        <= '0;
         pv_q         <= 1'b0;
         psel_q       <= 2'd0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         pv_q         <= mul_en;
         psel_q       <= idx_q;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         if (accept) begin
            src1_q <= in_src1;
            src2_q <= in_src2;
            op_q   <= in_op;
         end
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;

endmodule

// File: tb/tb_nios_system_nios2_mul_sequencer.sv
// Scoreboard bench for the sequenced multiplier; honours NIOS_MUL_SEQ_EARLY_OUT_EN.
module tb_nios_system_nios2_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_src1 = '0;
   logic [31:0] in_src2 = '0;
   logic [1:0]  in_op = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        busy;

`ifdef NIOS_MUL_SEQ_EARLY_OUT_EN
   localparam int MUL_LAT = 4;
`else
   localparam int MUL_LAT = 6;
`endif

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc_cyc;
      string       name;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] res;
      int          lat;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   nios_system_nios2_mul_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      timeout("wait_in_ready");
   endtask

   task automatic issue(input vec_t v);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      in_src1  = v.a;
      in_src2  = v.b;
      in_op    = v.op;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sbq.push_back('{res: v.res, lat: v.lat, acc_cyc: cyc, name: v.name});
   endtask

   // Monitor: compare result and latency on each rising out_valid.
   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (out_valid && !prev) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", out_result);
            end else begin
               e = sbq.pop_front();
               check({e.name, "_result"}, out_result, e.res);
               check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
         end
         prev = out_valid;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit   ok;
      vec_t v;

      vecs.push_back('{"k_op01",   32'h00010000, 32'h00010000, 2'b01, 32'h00000001, 6});
      vecs.push_back('{"k_op00",   32'h00010000, 32'h00010000, 2'b00, 32'h00000000, MUL_LAT});
      vecs.push_back('{"ff_op01",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 6});
      vecs.push_back('{"ff_op10",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'h00000000, 6});
      vecs.push_back('{"ff_op00",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001, MUL_LAT});
      vecs.push_back('{"fe3_op11", 32'hFFFFFFFE, 32'h00000003, 2'b11, 32'hFFFFFFFF, 6});
      vecs.push_back('{"fe3_op01", 32'hFFFFFFFE, 32'h00000003, 2'b01, 32'h00000002, 6});
      vecs.push_back('{"fe3_op10", 32'hFFFFFFFE, 32'h00000003, 2'b10, 32'hFFFFFFFF, 6});
      vecs.push_back('{"s5_op11",  32'h00000005, 32'h80000000, 2'b11, 32'h00000002, 6});
      vecs.push_back('{"s5_op10",  32'h00000005, 32'h80000000, 2'b10, 32'hFFFFFFFD, 6});
      vecs.push_back('{"eo_op00",  32'h12345678, 32'h00000002, 2'b00, 32'h2468ACF0, MUL_LAT});
      vecs.push_back('{"eo_op01",  32'h12345678, 32'h00000002, 2'b01, 32'h00000000, 6});

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid",  32'(out_valid), 32'd0);
      check("rst_busy",       32'(busy), 32'd0);
      check("rst_in_ready",   32'(in_ready), 32'd1);
      check("rst_out_result", out_result, 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) issue(vecs[i]);

      // Backpressure: result must hold and new requests must be ignored.
      wait_ready(ok);
      out_ready = 1'b0;
      issue('{"bp", 32'h00030000, 32'h00070000, 2'b01, 32'h00000015, 6});
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (out_valid) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!ok) timeout("bp_wait_valid");
      in_src1  = 32'hDEADBEEF;
      in_src2  = 32'h00000009;
      in_op    = 2'b01;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_hold_result", out_result, 32'h00000015);
         check("bp_hold_valid",  32'(out_valid), 32'd1);
         check("bp_in_ready",    32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_no_same_cycle", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("bp_ignored_busy", 32'(busy), 32'd0);

      // Abort: reset dropped at E3 of an op=01 job.
      wait_ready(ok);
      in_src1  = 32'hFFFFFFFF;
      in_src2  = 32'hFFFFFFFF;
      in_op    = 2'b01;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("abort_out_valid",  32'(out_valid), 32'd0);
      check("abort_busy",       32'(busy), 32'd0);
      check("abort_in_ready",   32'(in_ready), 32'd1);
      check("abort_out_result", out_result, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      issue('{"post_abort", 32'h00010000, 32'h00010000, 2'b01, 32'h00000001, 6});

      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (sbq.size() == 0 && !out_valid) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check("sb_drained", 32'(sbq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
